// File: rtl/char_buffer_pkg.sv
// Shared constants and types for the character buffer command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package char_buffer_pkg;

    // Screen geometry and RAM sizing
    localparam int COLS      = 80;
    localparam int ROWS      = 25;
    localparam int BUF_SIZE  = COLS * ROWS;
    localparam int ADDR_BITS = 11;

    // Command opcodes presented on cmd_op
    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_CLEAR  = 2'd1,
        OP_SCROLL = 2'd2,
        OP_NOP    = 2'd3
    } op_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_CLR     = 3'd2,
        ST_SC_COPY = 3'd3,
        ST_SC_FILL = 3'd4
    } state_e;

endpackage

// File: rtl/char_buffer_ctrl.sv
// Command sequencer for the 80x25 character RAM: single writes, range fills, one-line scroll-up.
// Latency: first RAM write one cycle after acceptance; scroll copy writes trail their reads by two cycles.
// Backpressure: cmd_ready only in IDLE; video reads always win the shared read port, stalling scroll copies.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake; cmd_op/addr/len/data sampled at acceptance
//   busy                            high while a command is executing
//   vid_read_en, vid_raddr          scanout read request (highest priority)
//   buf_raddr, buf_read_en          to RAM read port (combinational mux)
//   buf_dout                        RAM read data, one cycle after the read
//   buf_waddr, buf_din, buf_write_en  to RAM write port (registered)
module char_buffer_ctrl
    import char_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [ADDR_BITS-1:0] cmd_len,
    input  logic [7:0]           cmd_data,
    output logic                 busy,

    input  logic                 vid_read_en,
    input  logic [ADDR_BITS-1:0] vid_raddr,

    output logic [ADDR_BITS-1:0] buf_raddr,
    output logic                 buf_read_en,
    input  logic [7:0]           buf_dout,

    output logic [ADDR_BITS-1:0] buf_waddr,
    output logic [7:0]           buf_din,
    output logic                 buf_write_en
);

    // Address counters carry one extra bit so that reaching BUF_SIZE (and
    // cmd_addr+1 at the top of the address space) never wraps to zero.
    localparam int CNT_W = ADDR_BITS + 1;

    localparam logic [CNT_W-1:0]     BUF_END    = CNT_W'(BUF_SIZE);
    localparam logic [CNT_W-1:0]     SRC_START  = CNT_W'(COLS);
    localparam logic [CNT_W-1:0]     FILL_START = CNT_W'(BUF_SIZE - COLS);
    localparam logic [ADDR_BITS-1:0] FILL_LEN   = ADDR_BITS'(COLS);

    state_e               state_q, state_d;

    // Scroll copy source pointer and destination of the read in flight
    logic [CNT_W-1:0]     src_q, src_d;
    logic [ADDR_BITS-1:0] dst_q, dst_d;
    logic                 rd_vld_q, rd_vld_d;

    // Fill engine shared by CLEAR and the scroll bottom-line fill
    logic [CNT_W-1:0]     addr_q, addr_d;
    logic [ADDR_BITS-1:0] rem_q, rem_d;
    logic [7:0]           fill_q, fill_d;

    // Registered write port
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0] waddr_q, waddr_d;
    logic [7:0]           din_q, din_d;

    logic                 ctrl_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rd_vld_q <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
            fill_q   <= '0;
            wr_en_q  <= 1'b0;
            waddr_q  <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rd_vld_q <= rd_vld_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            fill_q   <= fill_d;
            wr_en_q  <= wr_en_d;
            waddr_q  <= waddr_d;
            din_q    <= din_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rd_vld_d = 1'b0;
        addr_d   = addr_q;
        rem_d    = rem_q;
        fill_d   = fill_q;
        wr_en_d  = 1'b0;
        waddr_d  = waddr_q;
        din_d    = din_q;
        ctrl_rd  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The first write of WRITE/CLEAR is launched on the accept
                // edge so it appears on the RAM port the very next cycle.
                if (cmd_valid) begin
                    case (op_e'(cmd_op))
                        OP_WRITE: begin
                            state_d = ST_WR;
                            wr_en_d = 1'b1;
                            waddr_d = cmd_addr;
                            din_d   = cmd_data;
                        end
                        OP_CLEAR: begin
                            if (cmd_len != '0) begin
                                state_d = ST_CLR;
                                fill_d  = cmd_data;
                                addr_d  = {1'b0, cmd_addr} + CNT_W'(1);
                                rem_d   = cmd_len - ADDR_BITS'(1);
                                if ({1'b0, cmd_addr} < BUF_END) begin
                                    wr_en_d = 1'b1;
                                    waddr_d = cmd_addr;
                                    din_d   = cmd_data;
                                end
                            end
                        end
                        OP_SCROLL: begin
                            state_d = ST_SC_COPY;
                            fill_d  = cmd_data;
                            src_d   = SRC_START;
                        end
                        default: ;
                    endcase
                end
            end

            ST_WR: begin
                state_d = ST_IDLE;
            end

            ST_CLR, ST_SC_FILL: begin
                // Stop on length exhausted or on running off the end of the
                // buffer; out-of-range addresses are never written.
                if (rem_q != '0 && addr_q < BUF_END) begin
                    wr_en_d = 1'b1;
                    waddr_d = addr_q[ADDR_BITS-1:0];
                    din_d   = fill_q;
                    addr_d  = addr_q + CNT_W'(1);
                    rem_d   = rem_q - ADDR_BITS'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SC_COPY: begin
                // A read is only issued when video leaves the port free; a
                // blocked cycle simply retries the same src next cycle.
                ctrl_rd  = (src_q < BUF_END) && !vid_read_en;
                rd_vld_d = ctrl_rd;
                if (ctrl_rd) begin
                    src_d = src_q + CNT_W'(1);
                    dst_d = ADDR_BITS'(src_q - SRC_START);
                end
                // Data from last cycle's read goes straight into the write
                // register, so nothing can be overwritten by a later read.
                if (rd_vld_q) begin
                    wr_en_d = 1'b1;
                    waddr_d = dst_q;
                    din_d   = buf_dout;
                end
                if (src_q == BUF_END && rd_vld_q) begin
                    state_d = ST_SC_FILL;
                    addr_d  = FILL_START;
                    rem_d   = FILL_LEN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign busy         = ~cmd_ready;

    // Video owns the read port whenever it asks; no added latency for it.
    assign buf_raddr    = vid_read_en ? vid_raddr : src_q[ADDR_BITS-1:0];
    assign buf_read_en  = vid_read_en | ctrl_rd;

    assign buf_write_en = wr_en_q;
    assign buf_waddr    = waddr_q;
    assign buf_din      = din_q;

endmodule

// File: tb/tb_char_buffer_ctrl.sv
// Bench for char_buffer_ctrl: table of single-command vectors plus scroll, contention and reset sequences.
// Latency: expected RAM writes carry their required cycle where the timing is fixed.
// Backpressure: commands wait on cmd_ready; video reads are injected during scroll.
module tb_char_buffer_ctrl;
    import char_buffer_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [1:0]           cmd_op = 2'd3;
    logic [ADDR_BITS-1:0] cmd_addr = '0;
    logic [ADDR_BITS-1:0] cmd_len = '0;
    logic [7:0]           cmd_data = '0;
    logic                 busy;
    logic                 vid_read_en = 1'b0;
    logic [ADDR_BITS-1:0] vid_raddr = '0;
    logic [ADDR_BITS-1:0] buf_raddr;
    logic                 buf_read_en;
    logic [7:0]           buf_dout;
    logic [ADDR_BITS-1:0] buf_waddr;
    logic [7:0]           buf_din;
    logic                 buf_write_en;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    char_buffer_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_data     (cmd_data),
        .busy         (busy),
        .vid_read_en  (vid_read_en),
        .vid_raddr    (vid_raddr),
        .buf_raddr    (buf_raddr),
        .buf_read_en  (buf_read_en),
        .buf_dout     (buf_dout),
        .buf_waddr    (buf_waddr),
        .buf_din      (buf_din),
        .buf_write_en (buf_write_en)
    );

    // Behavioural character RAM with registered read data
    logic [7:0] mem [0:BUF_SIZE-1];
    logic       preload = 1'b0;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < BUF_SIZE; i++) mem[i] <= 8'(i);
        end else if (buf_write_en) begin
            mem[buf_waddr] <= buf_din;
        end
        if (buf_read_en) buf_dout <= mem[buf_raddr];
    end

    typedef struct {
        int addr;
        int data;
        int cyc;     // -1: cycle not checked
    } wexp_t;
    wexp_t expq[$];

    typedef struct {
        op_e op;
        int  addr;
        int  len;
        int  data;
        int  n_wr;
        int  rdy_off;   // cycles from acceptance edge to first ready cycle
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        wexp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && buf_write_en) begin
                if (expq.size() == 0) begin
                    chk("unexpected_write_addr", int'(buf_waddr), -1);
                end else begin
                    e = expq.pop_front();
                    chk("wr_addr", int'(buf_waddr), e.addr);
                    chk("wr_data", int'(buf_din), e.data);
                    if (e.cyc >= 0) chk("wr_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic send(input op_e op, input int addr, input int len, input int data,
                        output int a);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) chk("send_timeout", 0, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = ADDR_BITS'(addr);
        cmd_len   = ADDR_BITS'(len);
        cmd_data  = 8'(data);
        @(posedge clk);
        #1;
        a = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input int a, output int off);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 10000) begin
            @(negedge clk);
            w++;
        end
        off = cmd_ready ? (cyc - a + 1) : -1;
    endtask

    task automatic push_scroll(input int a, input int fill, input bit timed);
        for (int i = 0; i < BUF_SIZE - COLS; i++)
            expq.push_back('{i, (i + COLS) % 256, timed ? a + 2 + i : -1});
        for (int j = 0; j < COLS; j++)
            expq.push_back('{BUF_SIZE - COLS + j, fill, timed ? a + BUF_SIZE - COLS + 2 + j : -1});
    endtask

    task automatic do_preload();
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    task automatic check_scroll_mem(input string nm, input int fill, input int skip);
        int bad = 0;
        int exp;
        for (int i = 0; i < BUF_SIZE; i++) begin
            exp = (i < BUF_SIZE - COLS) ? (i + COLS) % 256 : fill;
            if (i != skip && int'(mem[i]) != exp) bad++;
        end
        chk(nm, bad, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"},    int'(cmd_ready), 1);
        chk({tag, "_busy"},         int'(busy), 0);
        chk({tag, "_buf_write_en"}, int'(buf_write_en), 0);
        chk({tag, "_buf_waddr"},    int'(buf_waddr), 0);
        chk({tag, "_buf_din"},      int'(buf_din), 0);
        chk({tag, "_buf_read_en"},  int'(buf_read_en), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[8];
        int   a, a2, off, k, w;

        vt[0] = '{OP_WRITE,  5,    0,  'h41, 1,  2};
        vt[1] = '{OP_WRITE,  1999, 0,  'h7e, 1,  2};
        vt[2] = '{OP_CLEAR,  1990, 20, 'h20, 10, 11};
        vt[3] = '{OP_CLEAR,  300,  0,  'h20, 0,  1};
        vt[4] = '{OP_NOP,    9,    9,  'h11, 0,  1};
        vt[5] = '{OP_CLEAR,  100,  5,  'h2a, 5,  6};
        vt[6] = '{OP_CLEAR,  1999, 1,  'h2e, 1,  2};
        vt[7] = '{OP_CLEAR,  0,    3,  'h00, 3,  4};

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single-command vectors
        for (int v = 0; v < 8; v++) begin
            send(vt[v].op, vt[v].addr, vt[v].len, vt[v].data, a);
            for (int j = 0; j < vt[v].n_wr; j++)
                expq.push_back('{vt[v].addr + j, vt[v].data, a + j});
            wait_ready(a, off);
            chk($sformatf("vec%0d_busy_t1", v), int'(busy), 0);
            chk($sformatf("vec%0d_ready_off", v), off, vt[v].rdy_off);
            chk($sformatf("vec%0d_pending", v), expq.size(), 0);
            if (vt[v].op == OP_WRITE)
                chk($sformatf("vec%0d_readback", v), int'(mem[vt[v].addr]), vt[v].data);
        end

        // Scroll, no video, with a WRITE held behind it
        do_preload();
        send(OP_SCROLL, 0, 0, 'h20, a);
        push_scroll(a, 'h20, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_addr  = ADDR_BITS'(7);
        cmd_data  = 8'h55;
        w = 0;
        @(negedge clk);
        chk("scroll_busy_t1", int'(busy), 1);
        while (!cmd_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("scroll_ready_off", cmd_ready ? cyc - a + 1 : -1, 2003);
        @(posedge clk);
        #1;
        a2 = cyc;
        cmd_valid = 1'b0;
        expq.push_back('{7, 'h55, a2});
        wait_ready(a2, off);
        chk("held_write_ready_off", off, 2);
        chk("held_pending", expq.size(), 0);
        check_scroll_mem("scroll_mem_bad", 'h20, 7);
        chk("held_write_mem", int'(mem[7]), 'h55);

        // Scroll with video reads every other cycle for the first 400 cycles
        do_preload();
        send(OP_SCROLL, 0, 0, 'h2d, a);
        push_scroll(a, 'h2d, 1'b0);
        w = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready || w > 6000) break;
            if (vid_read_en) begin
                chk("vid_raddr", int'(buf_raddr), int'(vid_raddr));
                chk("vid_read_en", int'(buf_read_en), 1);
            end
            @(posedge clk);
            #1;
            k = cyc - a;
            vid_read_en = (k % 2 == 1) && (k < 400);
            vid_raddr   = ADDR_BITS'((k * 37) % BUF_SIZE);
            w++;
        end
        vid_read_en = 1'b0;
        chk("vid_scroll_ready_off", cmd_ready ? cyc - a + 1 : -1, 2003 + 200);
        chk("vid_pending", expq.size(), 0);
        check_scroll_mem("vid_scroll_mem_bad", 'h2d, -1);

        // Reset mid-scroll
        do_preload();
        send(OP_SCROLL, 0, 0, 'h20, a);
        push_scroll(a, 'h20, 1'b0);
        repeat (600) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        expq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(OP_WRITE, 12, 0, 'h33, a);
        expq.push_back('{12, 'h33, a});
        wait_ready(a, off);
        chk("post_reset_ready_off", off, 2);
        chk("post_reset_mem", int'(mem[12]), 'h33);
        chk("post_reset_pending", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
